// File: rtl/mult_norm_round.sv
// Normalise/round stage behind the 24-bit Booth mantissa multiplier, as a two-stage valid/ready pipeline.
// Optional build macro MULT_RND_TRUNC_EN adds i_Round_Mode (1 = round toward zero, 0 = round-to-nearest-even).
module mult_norm_round #(
    parameter int PW = 48,
    parameter int MW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    i_Numerical_Precision,
    input  logic [PW-1:0] i_C_NUM,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [MW-1:0] o_MANT,
    output logic [1:0]    o_EXP_INC,
    output logic          o_ZERO,
    output logic          o_INEXACT,
    output logic          o_UNNORM,
    output logic          o_valid,
    input  logic          i_ready
`ifdef MULT_RND_TRUNC_EN
    ,
    input  logic          i_Round_Mode
`endif
);

    typedef struct packed {
        logic [MW-1:0] mant_pre;
        logic          guard;
        logic          sticky;
        logic          inc;
        logic          zero;
        logic          unnorm;
        logic [1:0]    prec;
        logic          rtz;
    } norm_t;

    typedef struct packed {
        logic [MW-1:0] mant;
        logic [1:0]    exp_inc;
        logic          zero;
        logic          inexact;
        logic          unnorm;
    } res_t;

    function automatic int mant_width(input logic [1:0] prec);
        case (prec)
            2'b01:   return 11;
            2'b10:   return 8;
            default: return MW;
        endcase
    endfunction

    logic          rtz_in;
    int            m1;
    int            m2;
    logic [PW-1:0] aligned;
    logic [PW-1:0] top;
    logic [MW-1:0] ones;
    logic          up;
    norm_t         norm;
    res_t          rnd;

    norm_t s1_q, s1_d;
    res_t  s2_q, s2_d;
    logic  s1_valid_q, s1_valid_d;
    logic  s2_valid_q, s2_valid_d;
    logic  s2_free;
    logic  in_fire;

`ifdef MULT_RND_TRUNC_EN
    assign rtz_in = i_Round_Mode;
`else
    assign rtz_in = 1'b0;
`endif

    // Stage 1: move bit hi of the valid 2m-bit field to the MSB, so every precision shares one datapath.
    always_comb begin
        m1      = mant_width(i_Numerical_Precision);
        aligned = (i_C_NUM & ({PW{1'b1}} >> (PW - 2 * m1))) << (PW - 2 * m1);
        top     = aligned[PW-1] ? aligned : (aligned << 1);
        // NOTE: every field gets a default before any conditional logic so no latch can be inferred.
        norm          = '0;
        norm.mant_pre = top[PW-1 -: MW] >> (MW - m1);
        norm.guard    = |(top & (PW'(1) << (PW - 1 - m1)));
        norm.sticky   = |(top & ~({PW{1'b1}} << (PW - 1 - m1)));
        norm.inc      = aligned[PW-1];
        norm.zero     = ~|aligned;
        norm.unnorm   = (|aligned) & ~(|aligned[PW-1 -: 2]);
        norm.prec     = i_Numerical_Precision;
        norm.rtz      = rtz_in;
    end

    // Stage 2: RNE increment; a carry out of an all-ones mantissa renormalises to 1.0 and bumps the exponent.
    always_comb begin
        m2          = mant_width(s1_q.prec);
        ones        = {MW{1'b1}} >> (MW - m2);
        up          = s1_q.guard & (s1_q.sticky | s1_q.mant_pre[0]) & ~s1_q.rtz;
        rnd         = '0;
        rnd.zero    = s1_q.zero;
        rnd.inexact = s1_q.guard | s1_q.sticky;
        rnd.unnorm  = s1_q.unnorm;
        if (up && (s1_q.mant_pre == ones)) begin
            rnd.mant    = MW'(1) << (m2 - 1);
            rnd.exp_inc = {1'b0, s1_q.inc} + 2'd1;
        end else begin
            rnd.mant    = s1_q.mant_pre + MW'(up);
            rnd.exp_inc = {1'b0, s1_q.inc};
        end
    end

    assign s2_free = ~s2_valid_q | i_ready;
    assign o_ready = ~rst & (~s1_valid_q | s2_free);
    assign in_fire = i_valid & o_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = 1'b0;
            if (s1_valid_q) begin
                s2_d = rnd;
            end
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_d       = norm;
        end
    end

    // NOTE: payload registers are reset along with the valids so every output reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign o_valid   = s2_valid_q;
    assign o_MANT    = s2_q.mant;
    assign o_EXP_INC = s2_q.exp_inc;
    assign o_ZERO    = s2_q.zero;
    assign o_INEXACT = s2_q.inexact;
    assign o_UNNORM  = s2_q.unnorm;

endmodule

// File: tb/tb_mult_norm_round.sv
// Directed bench for mult_norm_round: an arithmetic reference model plus a queue scoreboard checked every output transfer.
module tb_mult_norm_round;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  prec = 2'b00;
    logic [47:0] pnum = '0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        o_ready, o_valid;
    logic [23:0] o_MANT;
    logic [1:0]  o_EXP_INC;
    logic        o_ZERO, o_INEXACT, o_UNNORM;
`ifdef MULT_RND_TRUNC_EN
    logic        rnd_mode = 1'b0;
`endif

    always #5 clk = ~clk;

    mult_norm_round dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_Numerical_Precision (prec),
        .i_C_NUM               (pnum),
        .i_valid               (i_valid),
        .o_ready               (o_ready),
        .o_MANT                (o_MANT),
        .o_EXP_INC             (o_EXP_INC),
        .o_ZERO                (o_ZERO),
        .o_INEXACT             (o_INEXACT),
        .o_UNNORM              (o_UNNORM),
        .o_valid               (o_valid),
        .i_ready               (i_ready)
`ifdef MULT_RND_TRUNC_EN
        ,
        .i_Round_Mode          (rnd_mode)
`endif
    );

    typedef struct packed {
        logic [23:0] mant;
        logic [1:0]  inc;
        logic        zero;
        logic        inexact;
        logic        unnorm;
    } exp_t;

    typedef struct {
        exp_t e;
        int   acc;
        bit   lat_chk;
    } entry_t;

    int     n_vec = 0;
    int     n_bad = 0;
    int     cyc = 0;
    bit     lat_flag = 0;
    bit     toggle_rdy = 0;
    bit     hold_v = 0;
    exp_t   hold_val;
    exp_t   cur;
    entry_t ent;
    entry_t q[$];

    localparam int NV = 13;
    localparam logic [49:0] VEC [NV] = '{
        {2'b00, 48'h9000_0000_0000},
        {2'b00, 48'h4000_0040_0000},
        {2'b00, 48'h4000_00C0_0000},
        {2'b00, 48'h7FFF_FFC0_0000},
        {2'b01, 48'h0000_0030_0000},
        {2'b01, 48'h0000_0012_3456},
        {2'b10, 48'h0000_0000_0000},
        {2'b10, 48'h0000_0000_4000},
        {2'b10, 48'hFFFF_FFFF_FF81},
        {2'b11, 48'h0000_0000_0123},
        {2'b00, 48'h1000_0000_0000},
        {2'b01, 48'hABCD_EF1F_FC00},
        {2'b00, 48'h8000_0000_0001}
    };

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: round the 2m-bit product to m bits with plain integer arithmetic.
    function automatic exp_t model(input logic [1:0] pr, input logic [47:0] p);
        exp_t            r;
        longint unsigned x, mant, rem, half;
        int              m, sh;
        bit              up;
        m = (pr == 2'b01) ? 11 : (pr == 2'b10) ? 8 : 24;
        x = {16'h0, p} % (64'd1 << (2 * m));
        r = '0;
        if (x == 0) begin
            r.zero = 1'b1;
            return r;
        end
        r.unnorm = (x < (64'd1 << (2 * m - 2)));
        if (x >= (64'd1 << (2 * m - 1))) begin
            sh    = m;
            r.inc = 2'd1;
        end else begin
            sh    = m - 1;
            r.inc = 2'd0;
        end
        mant      = x >> sh;
        rem       = x - (mant << sh);
        half      = 64'd1 << (sh - 1);
        r.inexact = (rem != 0);
        up        = (rem > half) || ((rem == half) && (mant % 2 == 1));
        mant      = mant + up;
        if (mant == (64'd1 << m)) begin
            mant  = 64'd1 << (m - 1);
            r.inc = r.inc + 2'd1;
        end
        r.mant = mant[23:0];
        return r;
    endfunction

    // Scoreboard: push model result on input accept, compare on output transfer, check stability under stall.
    always @(negedge clk) begin
        cyc++;
        cur = {o_MANT, o_EXP_INC, o_ZERO, o_INEXACT, o_UNNORM};
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", cur, hold_val);
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no output", cur);
                end else begin
                    ent = q.pop_front();
                    check("result", cur, ent.e);
                    if (ent.lat_chk) check("latency", cyc - ent.acc, 2);
                end
            end
            hold_v   = o_valid && !i_ready;
            hold_val = cur;
            if (i_valid && o_ready) q.push_back('{model(prec, pnum), cyc, lat_flag});
        end
    end

    task automatic send(input logic [1:0] pr, input logic [47:0] p);
        int budget;
        bit ok;
        budget  = 0;
        prec    = pr;
        pnum    = p;
        i_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = o_ready;
            @(posedge clk);
            #1;
            if (toggle_rdy) i_ready = 1'($urandom_range(0, 1));
            budget++;
        end while (!ok && budget < 50);
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got o_ready=0 for 50 cycles, expected acceptance");
        end
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (q.size() != 0 && budget < 100) begin
            @(posedge clk);
            #1;
            i_ready = toggle_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            budget++;
        end
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", q.size(), 0);
    endtask

    task automatic stream_table();
        logic [49:0] v;
        for (int i = 0; i < NV; i++) begin
            v = VEC[i];
            send(v[49:48], v[47:0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: every output zero while rst is held, o_ready rises once it is released.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {o_valid, o_ready, o_MANT, o_EXP_INC, o_ZERO, o_INEXACT, o_UNNORM}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", o_ready, 1);
        check("valid_after_reset", o_valid, 0);

        // Hand-computed pins on the reference model.
        check("pin_fp32_1x1",   model(2'b00, 48'h4000_0000_0000), {24'h800000, 2'd0, 1'b0, 1'b0, 1'b0});
        check("pin_fp32_1.5sq", model(2'b00, 48'h9000_0000_0000), {24'h900000, 2'd1, 1'b0, 1'b0, 1'b0});
        check("pin_tie_even",   model(2'b00, 48'h4000_0040_0000), {24'h800000, 2'd0, 1'b0, 1'b1, 1'b0});
        check("pin_tie_odd",    model(2'b00, 48'h4000_00C0_0000), {24'h800002, 2'd0, 1'b0, 1'b1, 1'b0});
        check("pin_rnd_ovf",    model(2'b00, 48'h7FFF_FFC0_0000), {24'h800000, 2'd1, 1'b0, 1'b1, 1'b0});
        check("pin_fp16",       model(2'b01, 48'h0000_0030_0000), {24'h000600, 2'd1, 1'b0, 1'b0, 1'b0});
        check("pin_bf16_zero",  model(2'b10, 48'h0000_0000_0000), {24'h000000, 2'd0, 1'b1, 1'b0, 1'b0});
        check("pin_bf16_inc2",  model(2'b10, 48'hFFFF_FFFF_FF81), {24'h000080, 2'd2, 1'b0, 1'b1, 1'b0});
        check("pin_unnorm",     model(2'b11, 48'h0000_0000_0123), {24'h000000, 2'd0, 1'b0, 1'b1, 1'b1});

        // First item with no stall: latency is measured by the scoreboard.
        @(posedge clk);
        #1;
        lat_flag = 1'b1;
        send(2'b00, 48'h4000_0000_0000);
        lat_flag = 1'b0;
        drain();

        // Mixed precisions back-to-back, then again under random downstream stalls.
        stream_table();
        drain();
        toggle_rdy = 1'b1;
        stream_table();
        drain();
        toggle_rdy = 1'b0;

        // Full stall: two items buffered, o_ready low, the rest follow once i_ready returns.
        i_ready = 1'b0;
        send(2'b00, 48'h4000_00C0_0000);
        send(2'b01, 48'h0000_0030_0000);
        prec    = 2'b10;
        pnum    = 48'h0000_0000_FF81;
        i_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stall_ready_low", o_ready, 0);
            @(posedge clk);
            #1;
        end
        i_ready = 1'b1;
        send(2'b10, 48'h0000_0000_FF81);
        send(2'b00, 48'h7FFF_FFC0_0000);
        drain();

        // Reset with two items in flight: both are flushed, nothing emerges.
        i_ready = 1'b0;
        send(2'b00, 48'h9000_0000_0000);
        send(2'b01, 48'h0000_0012_3456);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush_valid", o_valid, 0);
        i_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("flush_no_output", o_valid, 0);
        end
        check("flush_queue", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_norm_round.md
Name: mult_norm_round

Overview:
- Downstream stage of the 24-bit Booth mantissa multiplier.
- Takes its 48-bit raw product and precision code, and normalises the product to 1.f form.
- Rounds round-to-nearest-even to the precision's mantissa width.
- Reports the exponent increment plus zero/inexact/unnormalised flags.
- Two-stage valid/ready pipeline with full backpressure; feeds the FP result pack/exponent stage.

Parameters:
- PW, 48, input product width (fixed 2×24).
- MW, 24, output mantissa width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_Numerical_Precision  in  2  precision code: 00 FP32 (m=24), 01 FP16 (m=11), 10 BF16 (m=8), 11 treated as FP32.
- i_C_NUM  in  48  raw mantissa product, right-aligned, valid in low 2m bits.
- i_valid  in  1  input product valid.
- o_ready  out  1  block can accept input this cycle.
- o_MANT  out  24  rounded mantissa incl. hidden bit, right-aligned in low m bits, upper bits zero.
- o_EXP_INC  out  2  exponent increment, 0..2.
- o_ZERO  out  1  product zero.
- o_INEXACT  out  1  guard|sticky nonzero.
- o_UNNORM  out  1  product nonzero but bits hi and hi-1 both zero.
- o_valid  out  1  output valid.
- i_ready  in  1  downstream accepts output.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0, except o_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation: both stages flush; no output is produced for in-flight data.
- Handshake: transfer on i_valid&o_ready (in) and o_valid&i_ready (out).
  - Each stage loads when empty or when its content moves on the same cycle.
  - o_ready = !s1_valid | s1_advance.
  - Data and flags stay stable while o_valid=1 and i_ready=0.
  - Latency 2 cycles from input accept to o_valid with no stall.
  - Throughput 1/cycle; 2 items are buffered under full stall; no loss, no duplication.
- Precision is captured with its product and carried per-item; mixing precisions back-to-back is legal.
- Stage 1 (normalise), with hi = 2m-1:
  - If P[hi]=1: mant_pre = P[hi:hi-m+1], guard = P[hi-m], sticky = |P[hi-m-1:0], inc = 1.
  - Else: mant_pre = P[hi-1:hi-m], guard = P[hi-m-1], sticky = |P[hi-m-2:0], inc = 0.
  - Bits of i_C_NUM above hi are ignored.
- Stage 2 (round):
  - up = guard & (sticky | mant_pre[0]).
  - If up and mant_pre is all ones (m bits): o_MANT = 1<<(m-1), o_EXP_INC = inc+1.
  - Otherwise: o_MANT = mant_pre+up, o_EXP_INC = inc.
  - o_INEXACT = guard|sticky.
- Zero: low 2m bits all zero gives o_ZERO=1, o_MANT=0, o_EXP_INC=0, o_INEXACT=0, o_UNNORM=0.
- Unnormalised (P[hi]=P[hi-1]=0, nonzero): take the else-path unchanged (no further shift) and set o_UNNORM=1.

Optional Feature:
- Macro MULT_RND_TRUNC_EN.
- When defined: adds input port i_Round_Mode (1 bit), captured with each item. 1 selects round-toward-zero (up forced 0; o_INEXACT still reported). 0 selects RNE.
- When undefined: port absent, RNE only.

Test Plan:
- FP32 1.0×1.0, P=0x400000000000 -> o_MANT=0x800000, EXP_INC=0, INEXACT=0, o_valid exactly 2 cycles after accept.
- FP32 1.5×1.5, P=0x900000000000 -> MANT=0x900000, EXP_INC=1, INEXACT=0.
- FP32 ties:
  - P=0x400000400000 -> MANT=0x800000 (tie to even), INEXACT=1.
  - P=0x400000C00000 -> MANT=0x800002.
- FP32 round overflow, P=0x7FFFFFC00000 -> MANT=0x800000, EXP_INC=1, INEXACT=1.
- FP16, P=0x300000 -> MANT=0x600, EXP_INC=1.
- FP16 then BF16 back-to-back, with P=0 -> ZERO=1 on the zero item.
- Backpressure and reset:
  - Stream 4 items with i_ready low for cycles 2–5: o_ready drops after 2 held, all 4 emerge in order unchanged.
  - Assert rst with 2 in flight: o_valid=0 the next cycle, nothing emitted.
